// File: rtl/button_reader.sv
// button_reader: synchronises, debounces and encodes four raw push-buttons.
// Each channel has a two-flop synchroniser followed by a saturating-by-compare
// stability counter. Accepted levels generate one-cycle press/release pulses.
// Presses are encoded into a priority index (ch0 highest) with valid/multi flags.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_in,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_rel,
    output logic [1:0] key_idx,
    output logic       key_valid,
    output logic       key_multi
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Lowest-numbered set bit of a press vector; ch0 has top priority.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (v[0]) begin
            idx = 2'd0;
        end else if (v[1]) begin
            idx = 2'd1;
        end else if (v[2]) begin
            idx = 2'd2;
        end else if (v[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // True when two or more bits of the vector are set.
    function automatic logic more_than_one(input logic [3:0] v);
        logic [2:0] ones;
        ones = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
        return (ones > 3'd1);
    endfunction

    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       level_q;
    logic [3:0]       level_d;
    logic [3:0]       press_q;
    logic [3:0]       press_d;
    logic [3:0]       rel_q;
    logic [3:0]       rel_d;
    logic [1:0]       key_idx_q;
    logic [1:0]       key_idx_d;
    logic             key_valid_q;
    logic             key_valid_d;
    logic             key_multi_q;
    logic             key_multi_d;

    // Per-channel debounce decision, edge pulses and press encoding.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = CNT_ZERO;
            if (sync2_q[i] == level_q[i]) begin
                // Input agrees with the accepted level: any bounce restarts here.
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end

        press_d     = level_d & ~level_q;
        rel_d       = ~level_d & level_q;
        key_valid_d = |press_d;
        key_multi_d = more_than_one(press_d);
        if (key_valid_d) begin
            key_idx_d = lowest_idx(press_d);
        end else begin
            key_idx_d = key_idx_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 4'h0;
            sync2_q     <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            level_q     <= 4'h0;
            press_q     <= 4'h0;
            rel_q       <= 4'h0;
            key_idx_q   <= 2'd0;
            key_valid_q <= 1'b0;
            key_multi_q <= 1'b0;
        end else begin
            sync1_q     <= btn_in;
            sync2_q     <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q     <= level_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            key_idx_q   <= key_idx_d;
            key_valid_q <= key_valid_d;
            key_multi_q <= key_multi_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign btn_rel   = rel_q;
    assign key_idx   = key_idx_q;
    assign key_valid = key_valid_q;
    assign key_multi = key_multi_q;

endmodule
